// File: rtl/reaction_timer_pkg.sv
// Shared types for the reaction-time game controller: FSM state encoding
// and the 16-bit LFSR step used to randomise the pre-delay.
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GO   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Link between the reaction timer and the external 16-bit equality comparator.
// The timer is master (drives both operands), the comparator is slave.
interface reaction_timer_if;
  logic [15:0] count_o;
  logic [15:0] target_o;
  logic        match_i;

  modport master (output count_o, output target_o, input match_i);
  modport slave  (input count_o, input target_o, output match_i);
endinterface

// File: rtl/reaction_timer_ms_prescaler.sv
// Millisecond tick generator: free-running 0..TICK_DIV-1 counter whose
// synchronous clear realigns the tick phase to the moment a phase begins.
module ms_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == W'(TICK_DIV - 1));
    cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game controller: random pre-delay, GO light, then measures
// press latency in ms; the external comparator signals the end of each phase.
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int          TICK_DIV     = 50000,
  parameter logic [15:0] MIN_DELAY_MS = 16'd1000,
  parameter logic [15:0] DELAY_MASK   = 16'h0FFF,
  parameter logic [15:0] MAX_MS       = 16'd9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             press,
  reaction_timer_if.master cmp,
  output logic             led_go,
  output logic [15:0]      result_ms,
  output logic             result_valid,
  output logic             false_start,
  output logic             timeout
);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] count_q, count_d;
  logic [15:0] target_q, target_d;
  logic [15:0] result_q, result_d;
  logic        valid_q, valid_d, fs_q, fs_d, to_q, to_d, led_q, led_d;
  logic        tick, entry;

  ms_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (entry),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    result_d = result_q;
    valid_d  = valid_q;
    fs_d     = fs_q;
    to_d     = to_q;
    lfsr_d   = lfsr_next(lfsr_q);

    // press is checked before match_i so a same-cycle press always wins
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_WAIT;
          target_d = MIN_DELAY_MS + (lfsr_q & DELAY_MASK);
          valid_d  = 1'b0;
          fs_d     = 1'b0;
          to_d     = 1'b0;
        end
      end
      ST_WAIT: begin
        if (press) begin
          state_d = ST_DONE;
          fs_d    = 1'b1;
        end else if (cmp.match_i) begin
          state_d  = ST_GO;
          target_d = MAX_MS;
        end
      end
      ST_GO: begin
        if (press) begin
          state_d  = ST_DONE;
          result_d = count_q;
          valid_d  = 1'b1;
        end else if (cmp.match_i) begin
          state_d  = ST_DONE;
          result_d = MAX_MS;
          to_d     = 1'b1;
        end
      end
      default: ;
    endcase

    entry = (state_d != state_q);
    led_d = (state_d == ST_GO);

    count_d = count_q;
    if (entry)
      count_d = '0;
    else if (tick && (state_q == ST_WAIT || state_q == ST_GO) && count_q != 16'hFFFF)
      count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= LFSR_SEED;
      count_q  <= '0;
      target_q <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
      to_q     <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      count_q  <= count_d;
      target_q <= target_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      fs_q     <= fs_d;
      to_q     <= to_d;
      led_q    <= led_d;
    end
  end

  assign cmp.count_o  = count_q;
  assign cmp.target_o = target_q;
  assign led_go       = led_q;
  assign result_ms    = result_q;
  assign result_valid = valid_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;

endmodule
